// File: rtl/shared_line_arb_pkg.sv
// Shared types and helpers for the shared-line arbiter.
package shared_line_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    OVERRIDE = 2'd2
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Increment that sticks at vmax instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
    return (v >= vmax) ? vmax : v + 32'd1;
  endfunction

endpackage

// File: rtl/shared_line_arb_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping around.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  int unsigned best_dist;

  // Distance from the pointer to candidate c going upward with wrap.
  function automatic int unsigned ring_dist(input int unsigned c, input int unsigned p);
    return (c >= p) ? (c - p) : (c + N_REQ - p);
  endfunction

  always_comb begin
    found     = 1'b0;
    idx       = '0;
    best_dist = N_REQ;
    for (int c = 0; c < N_REQ; c++) begin
      if (req[c] && (ring_dist(32'(c), 32'(ptr)) < best_dist)) begin
        best_dist = ring_dist(32'(c), 32'(ptr));
        found     = 1'b1;
        idx       = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/shared_line_arb.sv
// Round-robin owner of a shared 1-bit line with a forced override and a
// saturating contention counter for debug.
module shared_line_arb
  import shared_line_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned HOLD_MAX = 3,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned OWN_W   = clog2_min1(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  input  logic [N_REQ-1:0] din,
  input  logic             ovr_en,
  input  logic             ovr_val,
  output logic             line_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic             gnt_vld,
  output logic [OWN_W-1:0] owner_o,
  output logic             busy,
  output logic [CNT_W-1:0] contention_cnt
);

  localparam int unsigned HOLD_W  = $clog2(HOLD_MAX + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [OWN_W-1:0]  rr_ptr;

  logic              pick_found;
  logic [OWN_W-1:0]  pick_idx;
  logic              keep_c;
  logic              contended_c;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (OWN_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The holder keeps the line only while it both requests and locks, up to HOLD_MAX.
  assign keep_c = (state == GRANT) && req[owner_o] && lock[owner_o] &&
                  (hold_cnt < HOLD_W'(HOLD_MAX));

  assign contended_c = ($countones(req) >= 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      rr_ptr         <= '0;
      line_o         <= 1'b0;
      gnt_o          <= '0;
      gnt_vld        <= 1'b0;
      owner_o        <= '0;
      busy           <= 1'b0;
      contention_cnt <= '0;
    end else if (ovr_en) begin
      // Override pre-empts everything but leaves the rotation where it was.
      state    <= OVERRIDE;
      hold_cnt <= '0;
      line_o   <= ovr_val;
      gnt_o    <= '0;
      gnt_vld  <= 1'b0;
      owner_o  <= '0;
      busy     <= 1'b1;
    end else if (keep_c) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
      line_o   <= din[owner_o];
    end else begin
      // Arbitration event: from IDLE, after OVERRIDE, or on release in GRANT.
      if (contended_c) begin
        contention_cnt <= CNT_W'(sat_inc(32'(contention_cnt), CNT_MAX));
      end
      if (pick_found) begin
        state    <= GRANT;
        hold_cnt <= HOLD_W'(1);
        line_o   <= din[pick_idx];
        gnt_o    <= N_REQ'(1) << pick_idx;
        gnt_vld  <= 1'b1;
        owner_o  <= pick_idx;
        busy     <= 1'b1;
        rr_ptr   <= (pick_idx == OWN_W'(N_REQ - 1)) ? '0 : pick_idx + OWN_W'(1);
      end else begin
        state    <= IDLE;
        hold_cnt <= '0;
        line_o   <= 1'b0;
        gnt_o    <= '0;
        gnt_vld  <= 1'b0;
        owner_o  <= '0;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shared_line_arb.sv
// Self-checking bench for shared_line_arb: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_shared_line_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned HM = 3;
  localparam int unsigned CW = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, lock, din;
  logic         ovr_en, ovr_val;
  logic         line_o;
  logic [N-1:0] gnt_o;
  logic         gnt_vld;
  logic [1:0]   owner_o;
  logic         busy;
  logic [CW-1:0] contention_cnt;

  int checks = 0;
  int errors = 0;

  // Model: owner -1 means nobody holds the line.
  bit m_ovr;
  int m_own, m_hold, m_ptr, m_cnt;
  bit m_line;

  always #5 clk = ~clk;

  shared_line_arb #(.N_REQ(N), .HOLD_MAX(HM), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .lock           (lock),
    .din            (din),
    .ovr_en         (ovr_en),
    .ovr_val        (ovr_val),
    .line_o         (line_o),
    .gnt_o          (gnt_o),
    .gnt_vld        (gnt_vld),
    .owner_o        (owner_o),
    .busy           (busy),
    .contention_cnt (contention_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int popcount(input logic [N-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(v[i]);
    return n;
  endfunction

  // Apply the arbitration rules to the inputs present at this edge.
  task automatic model_edge();
    int w;
    if (rst) begin
      m_ovr = 0; m_own = -1; m_hold = 0; m_ptr = 0; m_cnt = 0; m_line = 0;
    end else if (ovr_en) begin
      m_ovr = 1; m_own = -1; m_hold = 0; m_line = ovr_val;
    end else begin
      m_ovr = 0;
      if (m_own >= 0 && req[m_own] && lock[m_own] && m_hold < HM) begin
        m_hold++;
        m_line = din[m_own];
      end else begin
        if (popcount(req) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          m_own = w; m_hold = 1; m_line = din[w]; m_ptr = (w + 1) % N;
        end else begin
          m_own = -1; m_hold = 0; m_line = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("line_o",  32'(line_o),  32'(m_line));
    check("gnt_o",   32'(gnt_o),   (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
    check("gnt_vld", 32'(gnt_vld), (m_own >= 0) ? 32'd1 : 32'd0);
    check("owner_o", 32'(owner_o), (m_own >= 0) ? 32'(m_own) : 32'd0);
    check("busy",    32'(busy),    (m_ovr || m_own >= 0) ? 32'd1 : 32'd0);
    check("cnt",     32'(contention_cnt), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic r, input logic [N-1:0] q, input logic [N-1:0] l,
                        input logic [N-1:0] d, input logic oe, input logic ov);
    rst = r; req = q; lock = l; din = d; ovr_en = oe; ovr_val = ov;
  endtask

  task automatic do_reset();
    set_in(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    step();
    rst = 1'b0;
  endtask

  int exp_own [5];

  initial begin
    m_ovr = 0; m_own = -1; m_hold = 0; m_ptr = 0; m_cnt = 0; m_line = 0;
    set_in(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    // 1. Reset, then a single requester
    step();
    set_in(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    step();
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_cnt", 32'(contention_cnt), 32'd0);
    set_in(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step();
    check("t1_gnt",   32'(gnt_o),   32'h4);
    check("t1_owner", 32'(owner_o), 32'd2);
    check("t1_line",  32'(line_o),  32'd1);
    check("t1_busy",  32'(busy),    32'd1);

    // 2. Round robin across all four with saturating count
    do_reset();
    exp_own = '{0, 1, 2, 3, 0};
    set_in(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_owner", 32'(owner_o), 32'(exp_own[i]));
      check("t2_cnt", 32'(contention_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // 3. Hold limit with a locking holder and toggling data
    do_reset();
    exp_own = '{1, 1, 1, 3, 1};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 4'b1010, 4'b0010, {2'b00, 1'(i % 2), 1'b0}, 1'b0, 1'b0);
      step();
      check("t3_owner", 32'(owner_o), 32'(exp_own[i]));
      if (i < 3) check("t3_line", 32'(line_o), 32'(i % 2));
    end

    // 4. Override mid-grant, then wrap to requester 0
    do_reset();
    set_in(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0);
    step();
    check("t4_owner2", 32'(owner_o), 32'd2);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0);
      step();
      check("t4_vld", 32'(gnt_vld), 32'd0);
      check("t4_line", 32'(line_o), 32'd0);
    end
    set_in(1'b0, 4'b0101, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step();
    check("t4_owner0", 32'(owner_o), 32'd0);
    check("t4_cnt", 32'(contention_cnt), 32'd1);

    // 5. Release to idle leaves the counter alone
    set_in(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step();
    set_in(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_gnt",  32'(gnt_o), 32'd0);
    check("t5_cnt",  32'(contention_cnt), 32'd1);

    // 6. Reset while requester 3 holds
    set_in(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b0);
    step();
    check("t6_owner3", 32'(owner_o), 32'd3);
    set_in(1'b1, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b0);
    step();
    check("t6_rst_vld", 32'(gnt_vld), 32'd0);
    set_in(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    check("t6_owner0", 32'(owner_o), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(63) == 0), 4'($urandom), 4'($urandom | $urandom),
             4'($urandom), ($urandom_range(7) == 0), 1'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_line_arb.md
Name: shared_line_arb

Overview:
- Arbiter/scheduler for a single shared 1-bit line that several sources want to drive. It grants ownership to one requester at a time, round-robin.
- A forced override input takes priority over all requesters, in the same way an internal drive takes precedence over a port value.
- Sits between N driver blocks and the shared net consumer. It also counts contention events for debug.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- HOLD_MAX, 3, max consecutive cycles one requester may hold the grant (>=1)
- CNT_W, 8, width of saturating contention counter

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous reset, active-high
- req  input  N_REQ  per-requester drive request
- lock  input  N_REQ  per-requester request to keep the grant
- din  input  N_REQ  per-requester drive value
- ovr_en  input  1  force override of the line
- ovr_val  input  1  value driven while overriding
- line_o  output  1  registered shared-line value
- gnt_o  output  N_REQ  registered one-hot grant (0 when none)
- gnt_vld  output  1  registered; 1 when gnt_o nonzero
- owner_o  output  $clog2(N_REQ)  index of granted requester; 0 when none
- busy  output  1  state != IDLE
- contention_cnt  output  CNT_W  saturating count of contended arbitrations

Behaviour:
- States: IDLE, GRANT, OVERRIDE. All outputs are registered.
- Reset (rst=1 at an edge, any state):
  - state=IDLE; line_o=0, gnt_o=0, gnt_vld=0, owner_o=0, contention_cnt=0.
  - hold_cnt=0; rr pointer=0, so requester 0 has highest priority after reset.
  - Reset mid-grant or mid-override simply abandons the operation.
- Priority at each edge: rst > ovr_en > grant logic.
- OVERRIDE:
  - Any edge with ovr_en=1 moves to OVERRIDE.
  - gnt_o=0, gnt_vld=0, owner_o=0, line_o<=ovr_val, hold_cnt=0.
  - The rr pointer is preserved and no contention is counted.
  - The first edge with ovr_en=0 behaves as an IDLE edge.
- Arbitration event (from IDLE/OVERRIDE, or on release in GRANT):
  - Winner is the first set bit of req, searching from the rr pointer upward with wrap.
  - If a winner exists: state=GRANT, gnt_o=onehot(w), owner_o=w, hold_cnt=1, line_o<=din[w], rr pointer<=(w+1) mod N_REQ.
  - If no winner: state=IDLE, gnt_o=0, line_o<=0.
- Grant latency: req sampled at edge k gives gnt_o visible after edge k. Minimum latency is 1 cycle.
- GRANT, holder h, no override:
  - Keep: req[h]&&lock[h]&&hold_cnt<HOLD_MAX. Then hold_cnt++ and line_o<=din[h] (tracks holder every cycle).
  - Otherwise release and arbitrate in the same edge, with no idle bubble. The pointer is already past h, so h has lowest priority. h may regain the grant only if no other req is set.
- lock without req is ignored. A holder dropping req releases at the next edge.
- Contention: at each arbitration event with popcount(req)>=2, contention_cnt++, saturating at 2^CNT_W-1.
- Keep edges are not arbitration events and are never counted.
- Simultaneous ovr_en rising and holder release: override wins, no grant issued, no count.

Decomposition:
- Package shared_line_pkg:
  - state enum (IDLE, GRANT, OVERRIDE)
  - localparam function clog2_min1 for owner width
  - saturating-increment function
- Sub-module rr_pick (combinational): inputs req[N_REQ] and ptr; outputs found and idx (first set bit at/after ptr with wrap).
- The top holds the FSM, hold counter, pointer and output registers.

Test Plan:
(N_REQ=4, HOLD_MAX=3, CNT_W=2 unless noted)
1. Reset: rst=1 two cycles with random inputs -> all outputs 0. Release with req=4'b0100, din[2]=1 -> after next edge gnt_o=0100, owner_o=2, line_o=1, busy=1.
2. Round-robin: req=4'b1111, lock=0 held 5 cycles -> owners 0,1,2,3,0 on successive cycles. contention_cnt saturates at 3 after 3rd grant and stays 3.
3. Hold limit: req[1]=lock[1]=1 and req[3]=1 constant -> owner 1 for exactly 3 cycles, then 3, then 1. line_o follows din[1] toggling each cycle, one-cycle lag.
4. Override mid-grant: owner 2 holding, pulse ovr_en=1, ovr_val=0 for 2 cycles -> gnt_vld=0, line_o=0 for 2 cycles. With req=4'b0101, next grant goes to 0 (pointer at 3, wrap). Counter +1.
5. Release to idle: single requester 0 drops req -> next edge state IDLE, gnt_o=0, line_o=0, busy=0. contention_cnt unchanged.
6. Reset mid-grant: rst asserted while owner 3 holds with lock -> after edge all outputs 0. Next req=4'b1001 grants 0 (pointer reset).
